// File: rtl/ysyx_22041412_lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states, func3 codes and byte masks.
package ysyx_22041412_lsu_pkg;

  typedef enum logic [1:0] {
    LsuIdle,
    LsuReq,
    LsuResp,
    LsuHold
  } lsu_state_e;

  // Load func3 encodings
  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Ld  = 3'b011;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Lwu = 3'b110;
  localparam logic [2:0] F3Bad = 3'b111;

  // Store func3 encodings
  localparam logic [2:0] F3Sb = 3'b000;
  localparam logic [2:0] F3Sh = 3'b001;
  localparam logic [2:0] F3Sw = 3'b010;
  localparam logic [2:0] F3Sd = 3'b011;

  // Byte strobes for a lane-0 access of each size
  localparam logic [7:0] MaskB = 8'h01;
  localparam logic [7:0] MaskH = 8'h03;
  localparam logic [7:0] MaskW = 8'h0f;
  localparam logic [7:0] MaskD = 8'hff;

endpackage

// File: rtl/ysyx_22041412_lsu_fmt.sv
// Combinational lane formatting: store strobes/data, load extraction/extension, misalignment.
module ysyx_22041412_lsu_fmt
  import ysyx_22041412_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [2:0]      addr_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] sdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [7:0]      wmask_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            misalign_o
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] lane;

  assign shamt = {addr_i, 3'b000};

  // Store strobes/data and the size-dependent alignment check
  always_comb begin
    wdata_o    = sdata_i << shamt;
    wmask_o    = '0;
    misalign_o = 1'b0;
    case (func3_i[1:0])
      F3Sb[1:0]: begin
        wmask_o    = MaskB << addr_i;
        misalign_o = 1'b0;
      end
      F3Sh[1:0]: begin
        wmask_o    = MaskH << addr_i;
        misalign_o = addr_i[0];
      end
      F3Sw[1:0]: begin
        wmask_o    = MaskW << addr_i;
        misalign_o = |addr_i[1:0];
      end
      F3Sd[1:0]: begin
        wmask_o    = MaskD << addr_i;
        misalign_o = |addr_i;
      end
    endcase
  end

  // Move the addressed lane to bit 0, then sign- or zero-extend by access width
  always_comb begin
    lane = rdata_i >> shamt;
    case (func3_i)
      F3Lb:    load_data_o = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3Lh:    load_data_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3Lw:    load_data_o = {{(XLEN-32){lane[31]}}, lane[31:0]};
      F3Ld:    load_data_o = lane;
      F3Lbu:   load_data_o = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3Lhu:   load_data_o = {{(XLEN-16){1'b0}}, lane[15:0]};
      F3Lwu:   load_data_o = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: load_data_o = lane;
    endcase
  end

endmodule

// File: rtl/ysyx_22041412_lsu.sv
// Memory-access stage: one aligned 64-bit request per load/store, result to write-back.
module ysyx_22041412_lsu
  import ysyx_22041412_lsu_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic [XLEN-1:0] ex_sdata_i,
  input  logic            ex_load_i,
  input  logic            ex_store_i,
  input  logic [2:0]      ex_func3_i,
  input  logic [4:0]      ex_rd_i,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_wen_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [7:0]      mem_wmask_o,
  input  logic            mem_resp_valid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [XLEN-1:0] wb_result_o,
  output logic [4:0]      wb_rd_o,
  output logic            wb_err_o
);

  localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic [2:0]      func3_q, func3_d;
  logic [4:0]      rd_q, rd_d;
  logic            load_q, load_d;
  logic            store_q, store_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            busy;
  logic            accept;
  logic            ex_is_store;
  logic            ex_illegal;
  logic            timeout;
  logic [2:0]      fmt_addr;
  logic [2:0]      fmt_func3;
  logic [7:0]      fmt_wmask;
  logic [XLEN-1:0] fmt_wdata;
  logic [XLEN-1:0] fmt_load;
  logic            fmt_misalign;
  logic            req_store;

  assign busy       = (state_q == LsuReq) || (state_q == LsuResp);
  // Combinational from wb_ready_i so pass-through ops sustain one per cycle
  assign ex_ready_o = (state_q == LsuIdle) || ((state_q == LsuHold) && wb_ready_i);
  assign accept     = ex_valid_i && ex_ready_o;

  // A load flag wins if both flags are set
  assign ex_is_store = ex_store_i && !ex_load_i;
  assign ex_illegal  = (ex_load_i && (ex_func3_i == F3Bad)) || (ex_is_store && ex_func3_i[2]);
  assign timeout     = (MAX_WAIT != 0) && (cnt_q == CntW'(MAX_WAIT));

  // Accepts only happen outside REQ/RESP, so one formatter serves both the
  // incoming alignment check and the in-flight lane formatting.
  assign fmt_addr  = busy ? addr_q[2:0] : ex_result_i[2:0];
  assign fmt_func3 = busy ? func3_q : ex_func3_i;

  ysyx_22041412_lsu_fmt #(
    .XLEN (XLEN)
  ) u_fmt (
    .addr_i      (fmt_addr),
    .func3_i     (fmt_func3),
    .sdata_i     (sdata_q),
    .rdata_i     (mem_rdata_i),
    .wmask_o     (fmt_wmask),
    .wdata_o     (fmt_wdata),
    .load_data_o (fmt_load),
    .misalign_o  (fmt_misalign)
  );

  assign req_store       = (state_q == LsuReq) && store_q;
  assign mem_req_valid_o = (state_q == LsuReq);
  assign mem_addr_o      = mem_req_valid_o ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign mem_wen_o       = req_store;
  assign mem_wdata_o     = req_store ? fmt_wdata : '0;
  assign mem_wmask_o     = req_store ? fmt_wmask : '0;

  assign wb_valid_o  = (state_q == LsuHold);
  assign wb_result_o = result_q;
  assign wb_rd_o     = rd_q;
  assign wb_err_o    = err_q;

  // Next-state: transaction progress, timeout, then new-op capture on accept
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    func3_d  = func3_q;
    rd_d     = rd_q;
    load_d   = load_q;
    store_d  = store_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      LsuIdle: state_d = LsuIdle;
      LsuReq: begin
        cnt_d = cnt_q + CntW'(1);
        if (timeout) begin
          state_d  = LsuHold;
          result_d = addr_q;
          err_d    = 1'b1;
        end else if (mem_req_ready_i) begin
          state_d = LsuResp;
        end
      end
      LsuResp: begin
        cnt_d = cnt_q + CntW'(1);
        if (timeout) begin
          state_d  = LsuHold;
          result_d = addr_q;
          err_d    = 1'b1;
        end else if (mem_resp_valid_i) begin
          state_d  = LsuHold;
          result_d = store_q ? '0 : fmt_load;
          err_d    = 1'b0;
        end
      end
      LsuHold: begin
        if (wb_ready_i) begin
          state_d = LsuIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = LsuIdle;
    endcase

    if (accept) begin
      addr_d   = ex_result_i;
      sdata_d  = ex_sdata_i;
      func3_d  = ex_func3_i;
      rd_d     = ex_rd_i;
      load_d   = ex_load_i;
      store_d  = ex_is_store;
      result_d = ex_result_i;
      err_d    = 1'b0;
      if (ex_load_i || ex_store_i) begin
        if (ex_illegal || fmt_misalign) begin
          state_d = LsuHold;
          err_d   = 1'b1;
        end else begin
          state_d = LsuReq;
          cnt_d   = '0;
        end
      end else begin
        state_d = LsuHold;
      end
    end
  end

  // State and captured-op registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= LsuIdle;
      addr_q   <= '0;
      sdata_q  <= '0;
      func3_q  <= '0;
      rd_q     <= '0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sdata_q  <= sdata_d;
      func3_q  <= func3_d;
      rd_q     <= rd_d;
      load_q   <= load_d;
      store_q  <= store_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_lsu.sv
// Self-checking bench for ysyx_22041412_lsu against a behavioural load/store model.
module tb_ysyx_22041412_lsu;

  localparam int unsigned MaxWait = 8;
  localparam int          Budget  = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [63:0] ex_result_i = '0;
  logic [63:0] ex_sdata_i = '0;
  logic        ex_load_i = 1'b0;
  logic        ex_store_i = 1'b0;
  logic [2:0]  ex_func3_i = '0;
  logic [4:0]  ex_rd_i = '0;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [63:0] mem_addr_o;
  logic        mem_wen_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_resp_valid_i = 1'b0;
  logic [63:0] mem_rdata_i = '0;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b1;
  logic [63:0] wb_result_o;
  logic [4:0]  wb_rd_o;
  logic        wb_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22041412_lsu #(
    .XLEN     (64),
    .MAX_WAIT (MaxWait)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid_i       (ex_valid_i),
    .ex_ready_o       (ex_ready_o),
    .ex_result_i      (ex_result_i),
    .ex_sdata_i       (ex_sdata_i),
    .ex_load_i        (ex_load_i),
    .ex_store_i       (ex_store_i),
    .ex_func3_i       (ex_func3_i),
    .ex_rd_i          (ex_rd_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_addr_o       (mem_addr_o),
    .mem_wen_o        (mem_wen_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_wmask_o      (mem_wmask_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_rdata_i      (mem_rdata_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wb_result_o      (wb_result_o),
    .wb_rd_o          (wb_rd_o),
    .wb_err_o         (wb_err_o)
  );

  // ---------------- reference model ----------------
  function automatic int access_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_err(input logic ld, input logic [2:0] f3, input logic [63:0] a);
    int nb;
    nb = access_bytes(f3);
    if (ld && f3 == 3'd7) return 1'b1;
    if (!ld && f3 >= 3'd4) return 1'b1;
    return (a % nb) != 0;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a,
                                             input logic [63:0] rdata);
    int nb;
    logic [63:0] v;
    nb = access_bytes(f3);
    v  = rdata >> (8 * (a % 8));
    if (nb < 8) begin
      v = v & ((64'd1 << (8 * nb)) - 64'd1);
      // signed forms: subtract 2^width when the top bit of the value is set
      if (!f3[2] && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
    end
    return v;
  endfunction

  // ---------------- stimulus driver (no checking) ----------------
  task automatic mem_txn(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] sd, input logic [63:0] rdata,
                         input int ready_delay, input int resp_delay,
                         output logic got_req, output logic [63:0] r_addr,
                         output logic [63:0] r_wdata, output logic [7:0] r_mask,
                         output logic r_wen, output logic stable, output logic wb_seen,
                         output logic [63:0] wb_res, output logic wb_err,
                         output int n_req, output int n_resp, output int n_cyc);
    got_req = 1'b0; stable = 1'b1; wb_seen = 1'b0; n_req = 0; n_resp = 0; n_cyc = 0;
    r_addr = '0; r_wdata = '0; r_mask = '0; r_wen = 1'b0; wb_res = '0; wb_err = 1'b0;
    @(negedge clk);
    wb_ready_i  = 1'b1;
    ex_valid_i  = 1'b1;
    ex_load_i   = ld;
    ex_store_i  = st;
    ex_func3_i  = f3;
    ex_result_i = a;
    ex_sdata_i  = sd;
    ex_rd_i     = 5'($urandom_range(1, 31));
    for (int k = 1; k <= Budget && !wb_seen; k++) begin
      @(negedge clk);
      ex_valid_i       = 1'b0;
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b0;
      mem_rdata_i      = {$urandom, $urandom};
      n_cyc            = k;
      if (wb_valid_o) begin
        wb_seen = 1'b1;
        wb_res  = wb_result_o;
        wb_err  = wb_err_o;
      end else if (mem_req_valid_o) begin
        if (!got_req) begin
          r_addr = mem_addr_o; r_wdata = mem_wdata_o; r_mask = mem_wmask_o; r_wen = mem_wen_o;
        end else if (r_addr !== mem_addr_o || r_wdata !== mem_wdata_o ||
                     r_mask !== mem_wmask_o || r_wen !== mem_wen_o) begin
          stable = 1'b0;
        end
        got_req = 1'b1;
        if (n_req == ready_delay) mem_req_ready_i = 1'b1;
        n_req++;
      end else if (got_req) begin
        if (n_resp == resp_delay) begin
          mem_resp_valid_i = 1'b1;
          mem_rdata_i      = rdata;
        end
        n_resp++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_checks += 10;
    if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset ex_ready: got %b want 1", ex_ready_o); end
    if (mem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset mem_req_valid: got %b want 0", mem_req_valid_o); end
    if (mem_addr_o !== 64'd0) begin n_fail++; $display("FAIL reset mem_addr: got %h want 0", mem_addr_o); end
    if (mem_wen_o !== 1'b0) begin n_fail++; $display("FAIL reset mem_wen: got %b want 0", mem_wen_o); end
    if (mem_wdata_o !== 64'd0) begin n_fail++; $display("FAIL reset mem_wdata: got %h want 0", mem_wdata_o); end
    if (mem_wmask_o !== 8'd0) begin n_fail++; $display("FAIL reset mem_wmask: got %h want 0", mem_wmask_o); end
    if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset wb_valid: got %b want 0", wb_valid_o); end
    if (wb_result_o !== 64'd0) begin n_fail++; $display("FAIL reset wb_result: got %h want 0", wb_result_o); end
    if (wb_rd_o !== 5'd0) begin n_fail++; $display("FAIL reset wb_rd: got %h want 0", wb_rd_o); end
    if (wb_err_o !== 1'b0) begin n_fail++; $display("FAIL reset wb_err: got %b want 0", wb_err_o); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_passthrough();
    logic [63:0] vals [4];
    for (int i = 0; i < 4; i++) vals[i] = {$urandom, $urandom};
    @(negedge clk);
    wb_ready_i = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        ex_valid_i = 1'b1; ex_load_i = 1'b0; ex_store_i = 1'b0;
        ex_result_i = vals[i]; ex_rd_i = 5'(i + 1); ex_func3_i = 3'($urandom);
      end else begin
        ex_valid_i = 1'b0;
      end
      #1;
      if (i < 4) begin
        n_checks++;
        if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL pass ex_ready[%0d]: got %b want 1", i, ex_ready_o); end
      end
      if (i > 0) begin
        n_checks += 4;
        if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL pass wb_valid[%0d]: got %b want 1", i, wb_valid_o); end
        if (wb_result_o !== vals[i-1]) begin n_fail++; $display("FAIL pass result[%0d]: got %h want %h", i, wb_result_o, vals[i-1]); end
        if (wb_rd_o !== 5'(i)) begin n_fail++; $display("FAIL pass rd[%0d]: got %0d want %0d", i, wb_rd_o, i); end
        if (wb_err_o !== 1'b0) begin n_fail++; $display("FAIL pass err[%0d]: got %b want 0", i, wb_err_o); end
      end
      @(negedge clk);
    end
    n_checks++;
    if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL pass drain wb_valid: got %b want 0", wb_valid_o); end
  endtask

  task automatic test_load_byte();
    logic got, wen, stb, seen, err;
    logic [63:0] ra, rw, res;
    logic [7:0] rm;
    int nq, ns, nc;
    logic [63:0] want [2];
    want[0] = 64'hFFFF_FFFF_FFFF_FF80;
    want[1] = 64'h0000_0000_0000_0080;
    for (int i = 0; i < 2; i++) begin
      mem_txn(1'b1, 1'b0, (i == 0) ? 3'b000 : 3'b100, 64'h8000_0005, 64'd0,
              64'h0000_8000_0000_0000, 0, 1, got, ra, rw, rm, wen, stb, seen, res, err, nq, ns, nc);
      n_checks += 6;
      if (got !== 1'b1) begin n_fail++; $display("FAIL lb req[%0d]: got %b want 1", i, got); end
      if (ra !== 64'h8000_0000) begin n_fail++; $display("FAIL lb addr[%0d]: got %h want 80000000", i, ra); end
      if (wen !== 1'b0 || rm !== 8'h00) begin n_fail++; $display("FAIL lb wen/mask[%0d]: got %b/%h want 0/00", i, wen, rm); end
      if (seen !== 1'b1) begin n_fail++; $display("FAIL lb wb_seen[%0d]: got %b want 1", i, seen); end
      if (res !== want[i]) begin n_fail++; $display("FAIL lb result[%0d]: got %h want %h", i, res, want[i]); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL lb err[%0d]: got %b want 0", i, err); end
    end
  endtask

  task automatic test_store_half();
    logic got, wen, stb, seen, err;
    logic [63:0] ra, rw, res;
    logic [7:0] rm;
    int nq, ns, nc;
    mem_txn(1'b0, 1'b1, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_1234, 64'd0, 3, 0,
            got, ra, rw, rm, wen, stb, seen, res, err, nq, ns, nc);
    n_checks += 8;
    if (ra !== 64'h8000_0000) begin n_fail++; $display("FAIL sh addr: got %h want 80000000", ra); end
    if (wen !== 1'b1) begin n_fail++; $display("FAIL sh wen: got %b want 1", wen); end
    if (rm !== 8'hC0) begin n_fail++; $display("FAIL sh wmask: got %h want c0", rm); end
    if (rw[63:48] !== 16'h1234) begin n_fail++; $display("FAIL sh wdata: got %h want 1234", rw[63:48]); end
    if (stb !== 1'b1) begin n_fail++; $display("FAIL sh stable: got %b want 1", stb); end
    if (nq !== 4) begin n_fail++; $display("FAIL sh req cycles: got %0d want 4", nq); end
    if (seen !== 1'b1 || res !== 64'd0) begin n_fail++; $display("FAIL sh result: got %b/%h want 1/0", seen, res); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL sh err: got %b want 0", err); end
  endtask

  task automatic test_misaligned();
    logic got, wen, stb, seen, err;
    logic [63:0] ra, rw, res;
    logic [7:0] rm;
    int nq, ns, nc;
    mem_txn(1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 0, 0,
            got, ra, rw, rm, wen, stb, seen, res, err, nq, ns, nc);
    n_checks += 4;
    if (got !== 1'b0) begin n_fail++; $display("FAIL mis no_req: got %b want 0", got); end
    if (nc !== 1 || seen !== 1'b1) begin n_fail++; $display("FAIL mis latency: got %0d/%b want 1/1", nc, seen); end
    if (err !== 1'b1) begin n_fail++; $display("FAIL mis err: got %b want 1", err); end
    if (res !== 64'h8000_0002) begin n_fail++; $display("FAIL mis result: got %h want 80000002", res); end
  endtask

  task automatic test_random_mem();
    logic got, wen, stb, seen, err, ld, e_err;
    logic [63:0] ra, rw, res, a, sd, rdata, e_res, e_wdata;
    logic [7:0] rm, e_mask;
    logic [2:0] f3;
    int nq, ns, nc, nb;
    for (int i = 0; i < 40; i++) begin
      ld = 1'($urandom);
      f3 = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 7) > 5 ? $urandom_range(4, 7) : $urandom_range(0, 3));
      nb = access_bytes(f3);
      a  = {32'h0, 32'h8000_0000 | $urandom_range(0, 4095)};
      if ($urandom_range(0, 3) != 0) a = a - (a % nb);
      sd = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      mem_txn(ld, !ld, f3, a, sd, rdata, $urandom_range(0, 3), $urandom_range(0, 3),
              got, ra, rw, rm, wen, stb, seen, res, err, nq, ns, nc);
      e_err = model_err(ld, f3, a);
      n_checks += 3;
      if (seen !== 1'b1) begin n_fail++; $display("FAIL rnd[%0d] wb_seen: got %b want 1", i, seen); end
      if (err !== e_err) begin n_fail++; $display("FAIL rnd[%0d] err: got %b want %b", i, err, e_err); end
      if (got !== !e_err) begin n_fail++; $display("FAIL rnd[%0d] req issued: got %b want %b", i, got, !e_err); end
      if (e_err) begin
        n_checks++;
        if (res !== a) begin n_fail++; $display("FAIL rnd[%0d] err result: got %h want %h", i, res, a); end
      end else begin
        e_res   = ld ? model_load(f3, a, rdata) : 64'd0;
        e_mask  = ld ? 8'h00 : 8'(((1 << nb) - 1) << (a % 8));
        e_wdata = ld ? 64'd0 : (sd << (8 * (a % 8)));
        n_checks += 6;
        if (ra !== (a - (a % 8))) begin n_fail++; $display("FAIL rnd[%0d] addr: got %h want %h", i, ra, a - (a % 8)); end
        if (wen !== !ld) begin n_fail++; $display("FAIL rnd[%0d] wen: got %b want %b", i, wen, !ld); end
        if (rm !== e_mask) begin n_fail++; $display("FAIL rnd[%0d] wmask: got %h want %h", i, rm, e_mask); end
        if (rw !== e_wdata) begin n_fail++; $display("FAIL rnd[%0d] wdata: got %h want %h", i, rw, e_wdata); end
        if (stb !== 1'b1) begin n_fail++; $display("FAIL rnd[%0d] stable: got %b want 1", i, stb); end
        if (res !== e_res) begin n_fail++; $display("FAIL rnd[%0d] result f3=%0d: got %h want %h", i, f3, res, e_res); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] va, vb;
    va = {$urandom, $urandom};
    vb = {$urandom, $urandom};
    @(negedge clk);
    wb_ready_i = 1'b0;
    ex_valid_i = 1'b1; ex_load_i = 1'b0; ex_store_i = 1'b0; ex_result_i = va; ex_rd_i = 5'd5;
    @(negedge clk);
    ex_result_i = vb; ex_rd_i = 5'd6;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks += 4;
      if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp wb_valid[%0d]: got %b want 1", c, wb_valid_o); end
      if (wb_result_o !== va) begin n_fail++; $display("FAIL bp result[%0d]: got %h want %h", c, wb_result_o, va); end
      if (wb_rd_o !== 5'd5) begin n_fail++; $display("FAIL bp rd[%0d]: got %0d want 5", c, wb_rd_o); end
      if (ex_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp ex_ready[%0d]: got %b want 0", c, ex_ready_o); end
      @(negedge clk);
    end
    wb_ready_i = 1'b1;
    #1;
    n_checks++;
    if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp release ex_ready: got %b want 1", ex_ready_o); end
    @(negedge clk);
    ex_valid_i = 1'b0;
    n_checks += 2;
    if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp next wb_valid: got %b want 1", wb_valid_o); end
    if (wb_result_o !== vb || wb_rd_o !== 5'd6) begin n_fail++; $display("FAIL bp next op: got %h/%0d want %h/6", wb_result_o, wb_rd_o, vb); end
    @(negedge clk);
    n_checks++;
    if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp idle wb_valid: got %b want 0", wb_valid_o); end
  endtask

  task automatic test_timeout();
    logic got, wen, stb, seen, err;
    logic [63:0] ra, rw, res;
    logic [7:0] rm;
    int nq, ns, nc;
    // No request handshake: whole wait spent in REQ
    mem_txn(1'b1, 1'b0, 3'b011, 64'h8000_0108, 64'd0, 64'd0, 1000, 1000,
            got, ra, rw, rm, wen, stb, seen, res, err, nq, ns, nc);
    n_checks += 3;
    if (seen !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL to_req err: got %b/%b want 1/1", seen, err); end
    if (res !== 64'h8000_0108) begin n_fail++; $display("FAIL to_req result: got %h want 80000108", res); end
    if (nq !== int'(MaxWait) + 1) begin n_fail++; $display("FAIL to_req cycles: got %0d want %0d", nq, MaxWait + 1); end
    // Handshake at once, response never arrives
    mem_txn(1'b0, 1'b1, 3'b010, 64'h8000_0204, 64'hABCD, 64'd0, 0, 1000,
            got, ra, rw, rm, wen, stb, seen, res, err, nq, ns, nc);
    n_checks += 3;
    if (seen !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL to_resp err: got %b/%b want 1/1", seen, err); end
    if (res !== 64'h8000_0204) begin n_fail++; $display("FAIL to_resp result: got %h want 80000204", res); end
    if (nq + ns !== int'(MaxWait) + 1) begin n_fail++; $display("FAIL to_resp cycles: got %0d want %0d", nq + ns, MaxWait + 1); end
  endtask

  task automatic test_reset_mid_resp();
    @(negedge clk);
    wb_ready_i = 1'b1;
    ex_valid_i = 1'b1; ex_load_i = 1'b1; ex_store_i = 1'b0; ex_func3_i = 3'b011;
    ex_result_i = 64'h8000_0040; ex_rd_i = 5'd9;
    @(negedge clk);
    ex_valid_i = 1'b0;
    n_checks++;
    if (mem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid req: got %b want 1", mem_req_valid_o); end
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    rst = 1'b0;
    #1;
    n_checks += 3;
    if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid wb_valid: got %b want 0", wb_valid_o); end
    if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid ex_ready: got %b want 1", ex_ready_o); end
    if (mem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid req: got %b want 0", mem_req_valid_o); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_resp_valid_i = 1'b1;
    mem_rdata_i      = 64'h1122_3344_5566_7788;
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_checks += 2;
      if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL late_resp wb_valid[%0d]: got %b want 0", c, wb_valid_o); end
      if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL late_resp ex_ready[%0d]: got %b want 1", c, ex_ready_o); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_random_mem();
    test_backpressure();
    test_timeout();
    test_reset_mid_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
